// File: rtl/seg7_disp_pkg.sv
// Shared widths, FSM state type and write payload for the six-digit display arbiter.
package seg7_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIG_W      = 4;
  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned WORD_W     = NUM_DIGITS * DIG_W;
  localparam int unsigned OUT_W      = 32;
  localparam int unsigned PAD_W      = OUT_W - WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0]     data;
    logic [NUM_DIGITS-1:0] mask;
  } wr_req_t;

  // Widen a per-digit enable into a per-bit enable over the digit word.
  function automatic logic [WORD_W-1:0] mask_expand(input logic [NUM_DIGITS-1:0] m);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      r[d*DIG_W +: DIG_W] = {DIG_W{m[d]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_blink_gen.sv
// Free-running blink phase: toggles once every BLINK_DIV clock cycles.
module seg7_blink_gen #(
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic iCLK,
  input  logic iRST_N,
  output logic oPHASE
);

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign oPHASE = phase;

endmodule

// File: rtl/seg7_disp_arb.sv
// Six-digit display word owner: round-robin arbitration of two masked writers over a
// 4-phase req/grant handshake, plus per-digit blank/blink dark mask.
module seg7_disp_arb
  import seg7_disp_pkg::*;
#(
  parameter int unsigned       BLINK_DIV = 12500000,
  parameter logic [WORD_W-1:0] INIT_VAL  = 24'h000000
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [NUM_REQ-1:0]    iREQ,
  input  logic [WORD_W-1:0]     iDATA0,
  input  logic [NUM_DIGITS-1:0] iMASK0,
  input  logic [WORD_W-1:0]     iDATA1,
  input  logic [NUM_DIGITS-1:0] iMASK1,
  output logic [NUM_REQ-1:0]    oGNT,
  input  logic [NUM_DIGITS-1:0] iBLANK,
  input  logic [NUM_DIGITS-1:0] iBLINK,
  output logic [OUT_W-1:0]      oDIG,
  output logic [NUM_DIGITS-1:0] oOFF,
  output logic                  oUPD
);

  state_t                state, state_d;
  logic                  sel, sel_d;
  logic                  last, last_d;
  logic [WORD_W-1:0]     dig, dig_d;
  logic [NUM_REQ-1:0]    gnt, gnt_d;
  logic                  upd, upd_d;
  logic [NUM_DIGITS-1:0] off;
  logic                  phase;
  wr_req_t               wr_sel;
  logic [WORD_W-1:0]     wmask;

  seg7_blink_gen #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .oPHASE(phase)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      dig   <= INIT_VAL;
      gnt   <= '0;
      upd   <= 1'b0;
      off   <= '0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      last  <= last_d;
      dig   <= dig_d;
      gnt   <= gnt_d;
      upd   <= upd_d;
      off   <= iBLANK | (iBLINK & {NUM_DIGITS{phase}});
    end
  end

  // Arbitration and write sequencing; grant/update are single-cycle pulses out of WRITE.
  always_comb begin
    state_d = state;
    sel_d   = sel;
    last_d  = last;
    dig_d   = dig;
    gnt_d   = '0;
    upd_d   = 1'b0;
    if (sel) begin
      wr_sel.data = iDATA1;
      wr_sel.mask = iMASK1;
    end else begin
      wr_sel.data = iDATA0;
      wr_sel.mask = iMASK0;
    end
    wmask = mask_expand(wr_sel.mask);

    unique case (state)
      IDLE: begin
        if (iREQ != '0) begin
          // On a tie, the requester not served last wins.
          sel_d   = (iREQ == {NUM_REQ{1'b1}}) ? ~last : iREQ[1];
          state_d = WRITE;
        end
      end
      WRITE: begin
        dig_d      = (dig & ~wmask) | (wr_sel.data & wmask);
        gnt_d[sel] = 1'b1;
        upd_d      = |wr_sel.mask;
        last_d     = sel;
        state_d    = WAIT;
      end
      WAIT: begin
        if (!iREQ[sel]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign oGNT = gnt;
  assign oUPD = upd;
  assign oOFF = off;
  assign oDIG = {{PAD_W{1'b0}}, dig};

endmodule

// File: tb/tb_seg7_disp_arb.sv
// Randomized self-checking bench for seg7_disp_arb against a transaction-level model.
module tb_seg7_disp_arb;

  localparam int unsigned BD   = 4;
  localparam logic [23:0] INIT = 24'h000000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req   = 2'b00;
  logic [23:0] data_a [2];
  logic [5:0]  mask_a [2];
  logic [5:0]  blank = 6'b0;
  logic [5:0]  blink = 6'b0;
  logic [1:0]  gnt;
  logic [31:0] dig;
  logic [5:0]  off;
  logic        upd;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  logic [23:0]  m_word   = INIT;
  logic         m_last   = 1'b1;
  int unsigned  n        = 0;
  logic [1:0]   last_req = 2'b00;
  logic [1:0]   old_req  = 2'b00;
  logic         prev_gnt = 1'b0;
  logic         mon_en   = 1'b0;
  logic [5:0]   exp_off  = 6'b0;
  logic [1:0]   gq[$];

  int unsigned  age   [2];
  int unsigned  hold  [2];
  int unsigned  idle_c[2];
  logic         granted[2];

  seg7_disp_arb #(
    .BLINK_DIV(BD),
    .INIT_VAL (INIT)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .iREQ  (req),
    .iDATA0(data_a[0]),
    .iMASK0(mask_a[0]),
    .iDATA1(data_a[1]),
    .iMASK1(mask_a[1]),
    .oGNT  (gnt),
    .iBLANK(blank),
    .iBLINK(blink),
    .oDIG  (dig),
    .oOFF  (off),
    .oUPD  (upd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] apply_write(input logic [23:0] cur, input logic [23:0] d,
                                              input logic [5:0] m);
    logic [23:0] r;
    r = cur;
    for (int k = 0; k < 6; k++) if (m[k]) r[4*k +: 4] = d[4*k +: 4];
    return r;
  endfunction

  task automatic monitor();
    logic [1:0]  exp_g;
    logic [23:0] d;
    logic [5:0]  m;
    check("off", 32'(off), 32'(exp_off));
    if (gnt != 2'b00) begin
      check("gnt_pulse", 32'(prev_gnt), 32'(0));
      if (old_req == 2'b11) exp_g = m_last ? 2'b01 : 2'b10;
      else exp_g = old_req;
      check("gnt_who", 32'(gnt), 32'(exp_g));
      if (gnt == 2'b10) begin
        d = data_a[1]; m = mask_a[1]; m_last = 1'b1;
      end else begin
        d = data_a[0]; m = mask_a[0]; m_last = 1'b0;
      end
      m_word = apply_write(m_word, d, m);
      check("upd_wr", 32'(upd), 32'(m != 6'b0));
      gq.push_back(gnt);
    end else begin
      check("upd_idle", 32'(upd), 32'(0));
    end
    check("dig", dig, {8'h00, m_word});
    prev_gnt = (gnt != 2'b00);
  endtask

  task automatic tick();
    exp_off  = blank | ((((n / BD) % 2) == 1) ? blink : 6'b0);
    old_req  = last_req;
    last_req = req;
    @(posedge clk);
    n++;
    @(negedge clk);
    if (mon_en) monitor();
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check("rst_dig", dig, {8'h00, INIT});
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_off", 32'(off), 32'(0));
    check("rst_upd", 32'(upd), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    n        = 0;
    m_word   = INIT;
    m_last   = 1'b1;
    last_req = 2'b00;
    old_req  = 2'b00;
    prev_gnt = 1'b0;
    gq.delete();
    mon_en   = 1'b1;
  endtask

  task automatic serve_all(input int unsigned max_cyc);
    int unsigned c;
    c = 0;
    while (req != 2'b00 && c < max_cyc) begin
      tick();
      c++;
      if (gnt[0]) req[0] = 1'b0;
      if (gnt[1]) req[1] = 1'b0;
    end
    check("serve_done", 32'(req), 32'(0));
    req = 2'b00;
    repeat (2) tick();
  endtask

  initial begin
    data_a[0] = '0; data_a[1] = '0;
    mask_a[0] = '0; mask_a[1] = '0;
    @(negedge clk);
    apply_reset();

    // Idle after reset
    repeat (10) tick();
    check("idle_dig", dig, 32'h0);
    check("idle_gnt", 32'(gnt), 32'(0));
    check("idle_off", 32'(off), 32'(0));

    // Single write with latency check
    data_a[0] = 24'h123456; mask_a[0] = 6'h3F;
    req = 2'b01;
    tick();
    check("lat_k1", 32'(gnt), 32'(0));
    tick();
    check("lat_k2", 32'(gnt), 32'(2'b01));
    check("dig_k2", dig, 32'h00123456);
    check("upd_k2", 32'(upd), 32'(1));
    req[0] = 1'b0;
    tick();
    check("gnt_clr", 32'(gnt), 32'(0));
    check("upd_clr", 32'(upd), 32'(0));
    repeat (2) tick();

    // Simultaneous requests from a fresh reset, twice
    apply_reset();
    data_a[0] = 24'hAAAAAA; data_a[1] = 24'h555555;
    mask_a[0] = 6'h3F;      mask_a[1] = 6'h3F;
    for (int r = 0; r < 2; r++) begin
      gq.delete();
      req = 2'b11;
      serve_all(30);
      check("tie_cnt", 32'(gq.size()), 32'(2));
      if (gq.size() >= 2) check("tie_order", 32'({gq[0], gq[1]}), 32'(4'b0110));
      check("tie_dig", dig, 32'h00555555);
    end

    // Partial mask and zero mask
    data_a[0] = 24'h123456; mask_a[0] = 6'h3F;
    req = 2'b01;
    serve_all(20);
    data_a[1] = 24'hFFFFFF; mask_a[1] = 6'b000011;
    req = 2'b10;
    serve_all(20);
    check("part_dig", dig, 32'h001234FF);
    data_a[1] = 24'($urandom); mask_a[1] = 6'b0;
    gq.delete();
    req = 2'b10;
    serve_all(20);
    check("m0_cnt", 32'(gq.size()), 32'(1));
    check("m0_dig", dig, 32'h001234FF);

    // Blank and blink
    blink = 6'b000001; blank = 6'b100000;
    for (int i = 0; i < 24; i++) begin
      tick();
      check("blank5", 32'(off[5]), 32'(1));
    end
    blink = 6'b0; blank = 6'b0;
    tick();

    // Randomized contention
    for (int i = 0; i < 2; i++) begin
      age[i] = 0; hold[i] = 0; idle_c[i] = 0; granted[i] = 1'b0;
    end
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) blank = 6'($urandom);
      if ($urandom_range(0, 7) == 0) blink = 6'($urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (gnt[i]) granted[i] = 1'b1;
          if (granted[i]) begin
            if (hold[i] == 0) begin
              req[i]    = 1'b0;
              idle_c[i] = $urandom_range(0, 3);
            end else begin
              hold[i]--;
            end
          end else begin
            age[i]++;
            if (age[i] > 20) begin
              check("starve", age[i], 32'(20));
              age[i] = 0;
            end
          end
        end else if (idle_c[i] != 0) begin
          idle_c[i]--;
        end else if ($urandom_range(0, 2) == 0) begin
          data_a[i]  = 24'($urandom);
          mask_a[i]  = ($urandom_range(0, 5) == 0) ? 6'b0 : 6'($urandom);
          req[i]     = 1'b1;
          granted[i] = 1'b0;
          age[i]     = 0;
          hold[i]    = $urandom_range(0, 2);
        end
      end
    end
    for (int i = 0; i < 12 && req != 2'b00; i++) begin
      tick();
      if (gnt[0] || granted[0]) req[0] = 1'b0;
      if (gnt[1] || granted[1]) req[1] = 1'b0;
    end
    check("rand_drain", 32'(req), 32'(0));
    req = 2'b00;
    blank = 6'b0; blink = 6'b0;
    repeat (3) tick();

    // Reset while in WAIT with request held
    data_a[1] = 24'hABCDEF; mask_a[1] = 6'h3F;
    gq.delete();
    req = 2'b10;
    for (int i = 0; i < 10 && gq.size() == 0; i++) tick();
    check("pre_rst_gnt", 32'(gq.size()), 32'(1));
    tick();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gnt[1]) req[1] = 1'b0;
    end
    check("post_rst_cnt", 32'(gq.size()), 32'(1));
    if (gq.size() > 0) check("post_rst_gnt", 32'(gq[0]), 32'(2'b10));
    check("post_rst_dig", dig, 32'h00ABCDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
